// File: rtl/bird_physics.sv
// Fixed-point vertical physics for the player bird.
// Steps once per frame tick; IDLE/FLY/DEAD life-cycle.
module bird_physics #(
  parameter int Y_W     = 10,
  parameter int FRAC_W  = 4,
  parameter int V_W     = 10,
  parameter int Y_INIT  = 240,
  parameter int Y_MIN   = 16,
  parameter int Y_MAX   = 463,
  parameter int GRAVITY = 4,
  parameter int FLAP_V  = 64,
  parameter int TERM_V  = 96
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  freeze,
  input  logic                  flap,
  input  logic                  restart,
  output logic [Y_W-1:0]        bird_y,
  output logic signed [V_W-1:0] bird_vy,
  output logic [1:0]            state,
  output logic                  ground_hit
);

  localparam int P_W = Y_W + FRAC_W;
  localparam int S_W = P_W + 2;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_FLY  = 2'b01;
  localparam logic [1:0] S_DEAD = 2'b10;

  localparam logic [P_W-1:0] POS_INIT = P_W'(Y_INIT << FRAC_W);
  localparam logic [P_W-1:0] POS_MIN  = P_W'(Y_MIN << FRAC_W);
  localparam logic [P_W-1:0] POS_MAX  = P_W'(Y_MAX << FRAC_W);

  localparam logic signed [S_W-1:0] LIM_MIN = S_W'(Y_MIN << FRAC_W);
  localparam logic signed [S_W-1:0] LIM_MAX = S_W'(Y_MAX << FRAC_W);

  localparam logic signed [V_W:0]   GRAV_X = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W:0]   TERM_X = (V_W+1)'(-TERM_V);
  localparam logic signed [V_W-1:0] FLAP_X = V_W'(FLAP_V);

  logic [P_W-1:0]        pos;
  logic signed [V_W-1:0] vy;
  logic                  flap_q;
  logic                  pending;

  logic                  rise;
  logic                  flap_eff;
  logic                  do_step;
  logic signed [V_W:0]   vy_dec;
  logic signed [V_W-1:0] vy_n;
  logic signed [S_W-1:0] pos_sum;
  logic [P_W-1:0]        nxt_pos;
  logic signed [V_W-1:0] nxt_vy;
  logic                  die;

  assign rise     = flap & ~flap_q;
  assign flap_eff = pending | (rise & ~freeze);
  assign do_step  = (state == S_FLY) |
                    ((state == S_IDLE) & flap_eff);

  // Next velocity/position for a physics step, with clamps.
  always_comb begin
    vy_dec  = $signed({vy[V_W-1], vy}) - GRAV_X;
    vy_n    = (vy_dec < TERM_X) ? TERM_X[V_W-1:0]
                                : vy_dec[V_W-1:0];
    if (flap_eff) vy_n = FLAP_X;
    pos_sum = $signed({2'b00, pos}) +
              $signed({{(S_W-V_W){vy_n[V_W-1]}}, vy_n});
    nxt_pos = pos_sum[P_W-1:0];
    nxt_vy  = vy_n;
    die     = 1'b0;
    unique case (1'b1)
      (pos_sum >= LIM_MAX): begin
        nxt_pos = POS_MAX;
        nxt_vy  = '0;
      end
      (pos_sum <= LIM_MIN): begin
        nxt_pos = POS_MIN;
        nxt_vy  = '0;
        die     = 1'b1;
      end
      default: ;
    endcase
  end

  // State, flap capture and physics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pos        <= POS_INIT;
      vy         <= '0;
      ground_hit <= 1'b0;
      flap_q     <= 1'b0;
      pending    <= 1'b0;
    end else begin
      flap_q     <= flap;
      ground_hit <= 1'b0;
      if (restart) begin
        state   <= S_IDLE;
        pos     <= POS_INIT;
        vy      <= '0;
        pending <= 1'b0;
      end else if (!freeze) begin
        if (tick) begin
          pending <= 1'b0;
          if (do_step) begin
            pos        <= nxt_pos;
            vy         <= nxt_vy;
            state      <= die ? S_DEAD : S_FLY;
            ground_hit <= die;
          end
        end else if (rise && state != S_DEAD) begin
          pending <= 1'b1;
        end
      end
    end
  end

  assign bird_y  = pos[P_W-1:FRAC_W];
  assign bird_vy = vy;

endmodule

// File: tb/tb_bird_physics.sv
// Testbench for bird_physics.
// Directed scenarios then random stimulus vs a model.
module tb_bird_physics;

  logic              clk = 1'b0;
  logic              rst, tick, freeze, flap, restart;
  logic [9:0]        bird_y;
  logic signed [9:0] bird_vy;
  logic [1:0]        state;
  logic              ground_hit;

  int checks = 0;
  int errors = 0;

  // model state: pos/vel in 1/16 pixel units
  int m_pos, m_vy, m_st, m_gh;
  bit m_pend, m_fq;

  always #5 clk = ~clk;

  bird_physics dut (
    .clk(clk), .rst(rst), .tick(tick), .freeze(freeze),
    .flap(flap), .restart(restart), .bird_y(bird_y),
    .bird_vy(bird_vy), .state(state),
    .ground_hit(ground_hit)
  );

  task automatic chk(input string tag, input int obs,
                     input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_pos = 240 * 16; m_vy = 0; m_st = 0;
    m_gh = 0; m_pend = 0; m_fq = 0;
  endtask

  // one clock of game rules
  task automatic m_step(input bit t, fz, fl, rs);
    bit r, f;
    int v, p;
    r = fl && !m_fq;
    m_fq = fl;
    m_gh = 0;
    if (rs) begin
      m_st = 0; m_pos = 240 * 16; m_vy = 0; m_pend = 0;
    end else if (!fz) begin
      if (t) begin
        f = m_pend || r;
        if (m_st == 1 || (m_st == 0 && f)) begin
          if (f) v = 64;
          else begin
            v = m_vy - 4;
            if (v < -96) v = -96;
          end
          p = m_pos + v;
          m_st = 1;
          if (p >= 463 * 16) begin
            m_pos = 463 * 16; m_vy = 0;
          end else if (p <= 16 * 16) begin
            m_pos = 16 * 16; m_vy = 0;
            m_st = 2; m_gh = 1;
          end else begin
            m_pos = p; m_vy = v;
          end
        end
        m_pend = 0;
      end else if (r && m_st != 2) begin
        m_pend = 1;
      end
    end
  endtask

  task automatic cmp_all();
    chk("y", int'(bird_y), m_pos / 16);
    chk("vy", int'(bird_vy), m_vy);
    chk("st", int'(state), m_st);
    chk("gh", int'(ground_hit), m_gh);
  endtask

  task automatic cyc(input bit t, fz, fl, rs);
    tick = t; freeze = fz; flap = fl; restart = rs;
    @(posedge clk);
    m_step(t, fz, fl, rs);
    #1;
    cmp_all();
  endtask

  initial begin
    int mn, mx, n, ghc;
    rst = 1; tick = 0; freeze = 0; flap = 0; restart = 0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    rst = 0;
    chk("rst_y", int'(bird_y), 240);
    chk("rst_vy", int'(bird_vy), 0);
    chk("rst_st", int'(state), 0);
    chk("rst_gh", int'(ground_hit), 0);

    // idle ticks do nothing
    repeat (10) cyc(1, 0, 0, 0);
    chk("t1_y", int'(bird_y), 240);

    // first flap
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("t2_vy", int'(bird_vy), 64);
    chk("t2_y", int'(bird_y), 244);
    chk("t2_st", int'(state), 1);
    cyc(1, 0, 0, 0);
    chk("t2_vy2", int'(bird_vy), 60);
    chk("t2_y2", int'(bird_y), 247);

    // terminal velocity
    mn = 0;
    for (int i = 0; i < 45; i++) begin
      cyc(1, 0, 0, 0);
      if (int'(bird_vy) < mn) mn = int'(bird_vy);
    end
    chk("t3_min", mn, -96);
    chk("t3_vy", int'(bird_vy), -96);

    // fall to the ground
    n = 0; ghc = 0;
    while (state != 2'b10 && n < 200) begin
      cyc(1, 0, 0, 0);
      ghc += int'(ground_hit);
      n++;
    end
    chk("t4_bound", int'(n < 200), 1);
    for (int i = 0; i < 6; i++) begin
      cyc(i[0], 0, ~i[0], 0);
      ghc += int'(ground_hit);
    end
    chk("t4_ghc", ghc, 1);
    chk("t4_y", int'(bird_y), 16);
    chk("t4_vy", int'(bird_vy), 0);
    chk("t4_st", int'(state), 2);
    cyc(0, 1, 0, 1);
    chk("t4_rs_st", int'(state), 0);
    chk("t4_rs_y", int'(bird_y), 240);

    // flap every tick up to ceiling
    mx = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(0, 0, 1, 0);
      cyc(1, 0, 0, 0);
      if (int'(bird_y) > mx) mx = int'(bird_y);
    end
    chk("t5_max", mx, 463);
    chk("t5_y", int'(bird_y), 463);
    chk("t5_st", int'(state), 1);

    // freeze discards flaps; double rise = one impulse
    cyc(0, 0, 0, 1);
    cyc(1, 1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, i[0], 0);
    chk("t6_fz_st", int'(state), 0);
    cyc(1, 0, 0, 0);
    chk("t6_st", int'(state), 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("t6_vy", int'(bird_vy), 64);
    cyc(1, 0, 0, 0);
    chk("t6_vy2", int'(bird_vy), 60);

    // random play
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(3) == 0, $urandom_range(7) == 0,
          $urandom_range(2) == 0, $urandom_range(99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
